// File: rtl/imu_pkg.sv
// Shared types and constants for the IMU capture and readout stages.
// Holds the capture FSM state type, default widths and a saturating helper.
package imu_pkg;

  localparam int IMU_ADDR_WIDTH = 13;
  localparam int IMU_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_NOTIFY  = 2'd2
  } imu_state_t;

  // Drop counter increments but never wraps past 255.
  function automatic logic [7:0] sat_inc8(
    input logic [7:0] v
  );
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/imu_decim.sv
// Mod-DECIM sample counter; keep is high when the next valid sample is kept.
// Ports: clk, rst (async high), clear (zero count), advance (valid sample), keep.
module imu_decim #(
  parameter int DECIM = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic advance,
  output logic keep
);

  localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [CW-1:0] LAST = CW'(DECIM - 1);

  logic [CW-1:0] cnt;

  assign keep = (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (advance) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/imu_sample2bram.sv
// Captures one frame of decimated IMU samples into BRAM, then strobes the
// readout stage.
// Ports: clk, rst (async high), start, sample_data/sample_valid (no
// backpressure), reader_busy in; addr_bram/data_bram/en_bram/we_bram BRAM
// write port, imu_get_data frame-ready strobe, busy, drop_cnt (saturating).
module imu_sample2bram
  import imu_pkg::*;
#(
  parameter int ADDR_WIDTH    = IMU_ADDR_WIDTH,
  parameter int DATA_WIDTH    = IMU_DATA_WIDTH,
  parameter int FRAME_LEN     = 6,
  parameter int DECIM         = 1,
  parameter int GET_PULSE_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] sample_data,
  input  logic                  sample_valid,
  input  logic                  reader_busy,
  output logic [ADDR_WIDTH-1:0] addr_bram,
  output logic [DATA_WIDTH-1:0] data_bram,
  output logic                  en_bram,
  output logic                  we_bram,
  output logic                  imu_get_data,
  output logic                  busy,
  output logic [7:0]            drop_cnt
);

  localparam int PW = $clog2(GET_PULSE_CYC + 1);
  localparam logic [PW-1:0] PULSE_LAST =
    PW'(GET_PULSE_CYC);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR =
    ADDR_WIDTH'(FRAME_LEN - 1);

  imu_state_t            state;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [PW-1:0]         pulse_cnt;
  logic                  frame_done;
  logic                  accept;
  logic                  advance;
  logic                  keep;

  assign accept  = (state == ST_IDLE) && start
                && !reader_busy;
  assign advance = (state == ST_CAPTURE)
                && sample_valid;
  assign busy    = (state != ST_IDLE);

  imu_decim #(
    .DECIM(DECIM)
  ) u_decim (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .advance(advance),
    .keep   (keep)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      wr_ptr       <= '0;
      pulse_cnt    <= '0;
      frame_done   <= 1'b0;
      addr_bram    <= '0;
      data_bram    <= '0;
      en_bram      <= 1'b0;
      we_bram      <= 1'b0;
      imu_get_data <= 1'b0;
      drop_cnt     <= 8'd0;
    end else begin
      en_bram <= 1'b0;
      we_bram <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            state    <= ST_CAPTURE;
            wr_ptr   <= '0;
            drop_cnt <= 8'd0;
          end else if (sample_valid && frame_done) begin
            drop_cnt <= sat_inc8(drop_cnt);
          end
        end
        ST_CAPTURE: begin
          if (sample_valid && keep) begin
            en_bram   <= 1'b1;
            we_bram   <= 1'b1;
            addr_bram <= wr_ptr;
            data_bram <= sample_data;
            // Explicit wrap: FRAME_LEN may equal 2**ADDR_WIDTH.
            if (wr_ptr == LAST_ADDR) begin
              wr_ptr     <= '0;
              pulse_cnt  <= '0;
              frame_done <= 1'b1;
              state      <= ST_NOTIFY;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
          end
        end
        ST_NOTIFY: begin
          if (sample_valid) begin
            drop_cnt <= sat_inc8(drop_cnt);
          end
          // First NOTIFY cycle is the last write; strobe follows.
          if (pulse_cnt == PULSE_LAST) begin
            imu_get_data <= 1'b0;
            state        <= ST_IDLE;
          end else begin
            imu_get_data <= 1'b1;
            pulse_cnt    <= pulse_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/imu_sample2bram.md
IMU_SAMPLE2BRAM -- requirements
Module: imu_sample2bram

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 13, BRAM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, sample and BRAM word width.
REQ-003 SHALL have parameter FRAME_LEN, default 6, samples per frame; legal range 1..2**ADDR_WIDTH.
REQ-004 SHALL have parameter DECIM, default 1, keep every DECIM-th valid sample; legal range >=1.
REQ-005 SHALL have parameter GET_PULSE_CYC, default 16, imu_get_data high time in clk cycles; legal range >=1.
REQ-006 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port start, input, 1, request capture of one frame.
REQ-009 SHALL have port sample_data, input, DATA_WIDTH, IMU sample word.
REQ-010 SHALL have port sample_valid, input, 1, sample_data valid this cycle (no backpressure).
REQ-011 SHALL have port reader_busy, input, 1, downstream BRAM-to-UART stage is still reading.
REQ-012 SHALL have port addr_bram, output, ADDR_WIDTH, BRAM write address.
REQ-013 SHALL have port data_bram, output, DATA_WIDTH, BRAM write data.
REQ-014 SHALL have port en_bram, output, 1, BRAM port enable.
REQ-015 SHALL have port we_bram, output, 1, BRAM write enable.
REQ-016 SHALL have port imu_get_data, output, 1, frame-ready strobe to the downstream readout stage.
REQ-017 SHALL have port busy, output, 1, high in any state except IDLE.
REQ-018 SHALL have port drop_cnt, output, 8, count of valid samples lost.

Function
REQ-019 SHALL implement FSM IDLE, CAPTURE, NOTIFY.
REQ-020 IDLE->CAPTURE SHALL occur on a cycle with start=1 and reader_busy=0; start while reader_busy=1 SHALL be ignored without being held pending.
REQ-021 On entry to CAPTURE, wr_ptr and the decimation counter SHALL be 0 and drop_cnt SHALL clear to 0.
REQ-022 A sample_valid coincident with the accepting start cycle SHALL NOT be written.
REQ-023 In CAPTURE, each sample_valid SHALL advance a mod-DECIM counter; a sample SHALL be kept only when the counter is 0 before the increment.
REQ-024 A kept sample SHALL produce, registered, exactly one cycle later: en_bram=we_bram=1, addr_bram=wr_ptr, data_bram=sample_data.
REQ-025 en_bram and we_bram SHALL be 0 in every cycle without a write; addr_bram and data_bram SHALL hold their last values.
REQ-026 wr_ptr SHALL increment by 1 per kept sample; the write of address FRAME_LEN-1 SHALL move the FSM to NOTIFY and wrap wr_ptr to 0, including when FRAME_LEN=2**ADDR_WIDTH.
REQ-027 In NOTIFY, imu_get_data SHALL be 1 for exactly GET_PULSE_CYC cycles, starting the cycle after the last write; the FSM SHALL then return to IDLE.
REQ-028 sample_valid in NOTIFY or IDLE after the first frame SHALL increment drop_cnt, saturating at 255.
REQ-029 start in CAPTURE or NOTIFY SHALL be ignored.
REQ-030 FRAME_LEN=1 SHALL give one write then NOTIFY.

Reset
REQ-031 rst=1 SHALL asynchronously force IDLE, wr_ptr=0, decimation counter=0, addr_bram=0, data_bram=0, en_bram=0, we_bram=0, imu_get_data=0, busy=0, drop_cnt=0.
REQ-032 Reset mid-CAPTURE or mid-NOTIFY SHALL abort without further writes or strobe; a new start SHALL be needed after release.

Structure
REQ-033 A shared package imu_pkg SHALL hold the FSM state typedef and the default ADDR_WIDTH/DATA_WIDTH constants, shared with the readout stage.
REQ-034 The decimation counter SHALL be one sub-module, imu_decim (mod-DECIM counter with keep output).

Verification
REQ-035 Defaults, start, 6 valid samples 0x1234,+3 each cycle -> writes addr 0..5 with data 0x1234..0x1243, each 1 cycle after input; imu_get_data high 16 cycles; back to IDLE.
REQ-036 DECIM=3, 18 consecutive valid samples -> samples 0,3,6,9,12,15 written to addr 0..5.
REQ-037 start with reader_busy=1 -> no writes, busy=0; release reader_busy, start -> normal frame.
REQ-038 rst pulse after 3 writes -> outputs at reset values within the reset cycle; no imu_get_data; next start writes from addr 0.
REQ-039 4 valid samples during NOTIFY -> drop_cnt=4; 300 such samples -> drop_cnt=255; next accepted start -> 0.
REQ-040 ADDR_WIDTH=3, FRAME_LEN=8 -> writes addr 0..7, wr_ptr wraps to 0, next frame starts at 0.
